// File: rtl/mux_pkg.sv
// mux_pkg: shared select encodings and default width for the 2:1 mux
package mux_pkg;
   localparam logic SEL_D1        = 1'b0;
   localparam logic SEL_D2        = 1'b1;
   localparam int   DEFAULT_WIDTH = 1;
endpackage

// File: rtl/mux_21_sel.sv
// mux_21_sel: pure combinational 2:1 selector, reused by both output builds
module mux_21_sel
   import mux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             s,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] sel
);
   // route d2 when the select asks for it, otherwise d1; an unknown select propagates X
   always_comb sel = (s == SEL_D2) ? d2 : d1;
endmodule

// File: rtl/mux_21.sv
// mux_21: parameterised 2:1 data mux with optional synchronous-reset output register
module mux_21
   import mux_pkg::*;
#(
   parameter int          WIDTH   = DEFAULT_WIDTH,
   parameter bit          REG_OUT = 1'b1,
   parameter logic [63:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             S,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   output logic [WIDTH-1:0] Y
);
   logic [WIDTH-1:0] sel;

   mux_21_sel #(.WIDTH(WIDTH)) u_sel (
      .s  (S),
      .d1 (D1),
      .d2 (D2),
      .sel(sel)
   );

   if (REG_OUT) begin : g_reg
      // one-cycle registered output; reset only takes effect on a rising edge
      always_ff @(posedge CLK) Y <= RST ? RST_VAL[WIDTH-1:0] : sel;
   end else begin : g_comb
      // zero-latency build: clock and reset play no part
      always_comb Y = sel;
   end
endmodule

// File: tb/tb_mux_21.sv
// tb_mux_21: scoreboard bench covering registered 1-bit/8-bit and combinational 4-bit builds
module tb_mux_21;
   logic       clk = 1'b0;
   logic       rst;
   logic       s1, s8, s4;
   logic [0:0] d1a, d1b, y1;
   logic [7:0] d8a, d8b, y8;
   logic [3:0] d4a, d4b, y4;

   logic [0:0] q1[$];
   logic [7:0] q8[$];
   logic [3:0] q4[$];
   logic [0:0] e1;
   logic [7:0] e8;
   logic [3:0] e4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_21 #(.WIDTH(1), .REG_OUT(1'b1), .RST_VAL(64'h0)) dut1 (
      .CLK(clk), .RST(rst), .S(s1), .D1(d1a), .D2(d1b), .Y(y1)
   );

   mux_21 #(.WIDTH(8), .REG_OUT(1'b1), .RST_VAL(64'hFF)) dut8 (
      .CLK(clk), .RST(rst), .S(s8), .D1(d8a), .D2(d8b), .Y(y8)
   );

   mux_21 #(.WIDTH(4), .REG_OUT(1'b0), .RST_VAL(64'h0)) dut4 (
      .CLK(clk), .RST(rst), .S(s4), .D1(d4a), .D2(d4b), .Y(y4)
   );

   task automatic test_reset();
      rst = 1'b1; s1 = 1'b1; d1a = 1'b1; d1b = 1'b1;
      s8 = 1'b1; d8a = 8'hA5; d8b = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         q1.push_back(1'b0);
         q8.push_back(8'hFF);
         @(posedge clk); #1;
         e1 = q1.pop_front();
         n_checks++;
         if (y1 !== e1) begin
            n_fail++;
            $display("FAIL reset_w1 cycle %0d: got %b expected %b", i, y1, e1);
         end
         e8 = q8.pop_front();
         n_checks++;
         if (y8 !== e8) begin
            n_fail++;
            $display("FAIL reset_w8 cycle %0d: got %h expected %h", i, y8, e8);
         end
      end
   endtask

   task automatic test_sel_d1();
      rst = 1'b0; d1a = 1'b0; d1b = 1'b1; s1 = 1'b0;
      q1.push_back(1'b0);
      @(posedge clk); #1;
      e1 = q1.pop_front();
      n_checks++;
      if (y1 !== e1) begin
         n_fail++;
         $display("FAIL sel_d1_lo: got %b expected %b", y1, e1);
      end
      d1a = 1'b1;
      q1.push_back(1'b1);
      @(posedge clk); #1;
      e1 = q1.pop_front();
      n_checks++;
      if (y1 !== e1) begin
         n_fail++;
         $display("FAIL sel_d1_hi: got %b expected %b", y1, e1);
      end
   endtask

   task automatic test_sel_d2();
      d1a = 1'b0; d1b = 1'b1; s1 = 1'b1;
      q1.push_back(1'b1);
      @(posedge clk); #1;
      e1 = q1.pop_front();
      n_checks++;
      if (y1 !== e1) begin
         n_fail++;
         $display("FAIL sel_d2: got %b expected %b", y1, e1);
      end
      s1 = 1'b0;
      q1.push_back(1'b0);
      @(posedge clk); #1;
      e1 = q1.pop_front();
      n_checks++;
      if (y1 !== e1) begin
         n_fail++;
         $display("FAIL sel_back_d1: got %b expected %b", y1, e1);
      end
   endtask

   task automatic test_hold();
      s1 = 1'b0; d1a = 1'b0; d1b = 1'b1;
      #1 s1 = 1'b1;
      #1;
      n_checks++;
      if (y1 !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_glitch: got %b expected %b", y1, 1'b0);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (y8 !== 8'h3C && y1 !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_async_rst: got %b expected %b", y1, 1'b0);
      end
      rst = 1'b0;
      s1 = 1'b0;
      q1.push_back(1'b0);
      @(posedge clk); #1;
      e1 = q1.pop_front();
      n_checks++;
      if (y1 !== e1) begin
         n_fail++;
         $display("FAIL hold_edge: got %b expected %b", y1, e1);
      end
   endtask

   task automatic test_wide();
      d8a = 8'hA5; d8b = 8'h3C; s8 = 1'b0;
      q8.push_back(8'hA5);
      @(posedge clk); #1;
      e8 = q8.pop_front();
      n_checks++;
      if (y8 !== e8) begin
         n_fail++;
         $display("FAIL wide_d1: got %h expected %h", y8, e8);
      end
      s8 = 1'b1;
      q8.push_back(8'h3C);
      @(posedge clk); #1;
      e8 = q8.pop_front();
      n_checks++;
      if (y8 !== e8) begin
         n_fail++;
         $display("FAIL wide_d2: got %h expected %h", y8, e8);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (y8 !== 8'h3C) begin
         n_fail++;
         $display("FAIL wide_async_rst: got %h expected %h", y8, 8'h3C);
      end
      q8.push_back(8'hFF);
      @(posedge clk); #1;
      e8 = q8.pop_front();
      n_checks++;
      if (y8 !== e8) begin
         n_fail++;
         $display("FAIL wide_rst: got %h expected %h", y8, e8);
      end
      rst = 1'b0;
      q8.push_back(8'h3C);
      @(posedge clk); #1;
      e8 = q8.pop_front();
      n_checks++;
      if (y8 !== e8) begin
         n_fail++;
         $display("FAIL wide_after_rst: got %h expected %h", y8, e8);
      end
   endtask

   task automatic test_back_to_back();
      s8 = 1'b0; d8a = 8'h11; d8b = 8'h22;
      q8.push_back(8'h11);
      @(posedge clk); #1;
      s8 = 1'b1; d8a = 8'h55; d8b = 8'h77;
      q8.push_back(8'h77);
      e8 = q8.pop_front();
      n_checks++;
      if (y8 !== e8) begin
         n_fail++;
         $display("FAIL b2b_first: got %h expected %h", y8, e8);
      end
      @(posedge clk); #1;
      e8 = q8.pop_front();
      n_checks++;
      if (y8 !== e8) begin
         n_fail++;
         $display("FAIL b2b_simul_change: got %h expected %h", y8, e8);
      end
   endtask

   task automatic test_comb();
      logic [3:0] pat [4] = '{4'h6, 4'h9, 4'h6, 4'h9};
      d4a = 4'h6; d4b = 4'h9;
      for (int i = 0; i < 4; i++) begin
         s4 = i[0];
         rst = i[1];
         q4.push_back(pat[i]);
         #1;
         e4 = q4.pop_front();
         n_checks++;
         if (y4 !== e4) begin
            n_fail++;
            $display("FAIL comb_sweep %0d: got %h expected %h", i, y4, e4);
         end
      end
      rst = 1'b1;
      q4.push_back(4'h9);
      @(posedge clk); #1;
      e4 = q4.pop_front();
      n_checks++;
      if (y4 !== e4) begin
         n_fail++;
         $display("FAIL comb_rst_edge: got %h expected %h", y4, e4);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      s1 = 1'b0; d1a = '0; d1b = '0;
      s8 = 1'b0; d8a = '0; d8b = '0;
      s4 = 1'b0; d4a = '0; d4b = '0;
      @(negedge clk);
      test_reset();
      test_sel_d1();
      test_sel_d2();
      test_hold();
      test_wide();
      test_back_to_back();
      test_comb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_21.md
Name: mux_21

Overview:
- Parameterised 2:1 data multiplexer with an optional output register.
- Used as a generic select primitive in datapaths.
- S=0 routes D1 to Y; S=1 routes D2 to Y.
- Default build registers Y on CLK, with a synchronous active-high reset.

Parameters:
- WIDTH, 1, bit width of D1, D2 and Y; legal range 1..64.
- REG_OUT, 1, 1 = Y registered (1-cycle latency); 0 = Y purely combinational.
- RST_VAL, 0, value loaded into Y on reset when REG_OUT=1; truncated to WIDTH bits.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous reset, active-high; sampled on the rising CLK edge.
- S  input  1  select: 0 selects D1, 1 selects D2.
- D1  input  WIDTH  data input 1, selected when S=0.
- D2  input  WIDTH  data input 2, selected when S=1.
- Y  output  WIDTH  selected data.

Behaviour:
- Select function is sel = S ? D2 : D1, bitwise across all WIDTH bits. No arithmetic and no width conversion.
- REG_OUT=1:
  - At each rising CLK edge, if RST=1 then Y <= RST_VAL; else Y <= sel.
  - Latency is exactly 1 cycle from the S/D1/D2 change to Y.
  - Y is held between edges; input glitches between edges are invisible at Y.
- REG_OUT=0:
  - Y = sel, combinationally, with zero latency.
  - CLK and RST are unused; Y has no reset value.
- Reset is synchronous only. Asserting RST between edges has no effect until the next rising edge.
- Reset mid-operation: the edge with RST=1 forces RST_VAL regardless of S/D1/D2. The first edge after RST falls loads sel from the inputs present at that edge.
- Simultaneous change of S and the data inputs before an edge: Y reflects the new S with the new data. No blending of old and new values.
- X/Z on S (simulation only): Y goes X. Synthesis treats S as a plain select.
- Power-up: Y is undefined until the first reset edge. The bench must apply RST for at least 1 cycle.
- No handshake, no backpressure, no internal state beyond the Y register.

Decomposition:
- Shared package mux_pkg:
  - Constants SEL_D1 = 1'b0 and SEL_D2 = 1'b1.
  - Default WIDTH constant.
- Optional sub-module mux_21_sel: pure combinational selector (S, D1, D2 -> sel).
  - mux_21 wraps it with the REG_OUT generate branch for the output register.
  - Same selector reused in the REG_OUT=0 build.
- No FSM.

Test Plan:
- Reset: WIDTH=1, RST=1 for 2 cycles with D1=1, D2=1, S=1 -> Y=0 (RST_VAL) after the first edge; Y stays 0 while RST=1.
- Select D1: RST=0, D1=0, D2=1, S=0 -> Y=0 one cycle later. Then D1=1 -> Y=1 on the next edge.
- Select D2: D1=0, D2=1, S=1 -> Y=1 one cycle later. Toggling S to 0 -> Y=0 on the following edge.
- Latency/hold: change S mid-cycle 0->1->0 between two edges with D1=0, D2=1 -> Y stays 0; no glitch at Y.
- Wide bus: WIDTH=8, D1=8'hA5, D2=8'h3C:
  - S=0 -> Y=8'hA5; S=1 -> Y=8'h3C.
  - RST mid-stream (RST_VAL=8'hFF) -> Y=8'hFF on that edge, then 8'h3C the edge after RST drops.
- Combinational build: REG_OUT=0, WIDTH=4, D1=4'h6, D2=4'h9. Sweep S -> Y follows within a delta (4'h6/4'h9); RST toggling has no effect.
